// File: rtl/aon_lfclk_ctrl.sv
// Always-on low-frequency clock controller: programmable half-period divider with
// a valid/ready configuration port. Updates to divisor/enable while running are
// held until the next high-to-low boundary so clk_out never glitches.
module aon_lfclk_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_HALF = 127,
  parameter bit          DEF_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_en,
  output logic             cfg_done,
  output logic             clk_out,
  output logic             clk_tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_half
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StUpdWait = 2'd2;

  localparam logic [1:0]       StReset  = DEF_EN ? StRun : StIdle;
  localparam logic [CNT_W-1:0] DefHalf  = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cur_half_q, cur_half_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             pend_en_q, pend_en_d;
  // apply_q marks the edge a configuration took effect; cfg_done trails it by one cycle
  logic             apply_q, apply_d;
  logic             done_q;

  logic wrap;
  logic handshake;

  assign wrap      = (cnt_q == cur_half_q);
  assign cfg_ready = (state_q != StUpdWait);
  assign handshake = cfg_valid && cfg_ready;

  // Next-state: counting, handshake capture and boundary-aligned update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    cur_half_d  = cur_half_q;
    pend_half_d = pend_half_q;
    pend_en_d   = pend_en_q;
    apply_d     = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (handshake) begin
          cur_half_d = cfg_half;
          apply_d    = 1'b1;
          state_d    = cfg_en ? StRun : StIdle;
        end
      end
      StRun, StUpdWait: begin
        if (wrap) begin
          cnt_d     = '0;
          clk_out_d = ~clk_out_q;
          tick_d    = ~clk_out_q;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
        if (state_q == StRun && handshake) begin
          pend_half_d = cfg_half;
          pend_en_d   = cfg_en;
          state_d     = StUpdWait;
        end
        // Only a boundary seen while already pending applies, never the accepting one
        if (state_q == StUpdWait && wrap && clk_out_q) begin
          clk_out_d  = 1'b0;
          cnt_d      = '0;
          cur_half_d = pend_half_q;
          apply_d    = 1'b1;
          state_d    = pend_en_q ? StRun : StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      cur_half_q  <= DefHalf;
      pend_half_q <= '0;
      pend_en_q   <= 1'b0;
      apply_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      cur_half_q  <= cur_half_d;
      pend_half_q <= pend_half_d;
      pend_en_q   <= pend_en_d;
      apply_q     <= apply_d;
      done_q      <= apply_q;
    end
  end

  assign cfg_done = done_q;
  assign clk_out  = clk_out_q;
  assign clk_tick = tick_q;
  assign running  = (state_q == StRun) || (state_q == StUpdWait);
  assign cur_half = cur_half_q;

endmodule

// File: tb/tb_aon_lfclk_ctrl.sv
// Directed bench for aon_lfclk_ctrl. Cycle n is the state sampled #1 after the n-th
// rising edge following the reset edge. A 10-bit counter keeps the all-ones
// divisor case short.
module tb_aon_lfclk_ctrl;
  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_half = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_done;
  logic          clk_out;
  logic          clk_tick;
  logic          running;
  logic [CW-1:0] cur_half;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  aon_lfclk_ctrl #(.CNT_W(CW), .DEF_HALF(127), .DEF_EN(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_half  (cfg_half),
    .cfg_en    (cfg_en),
    .cfg_done  (cfg_done),
    .clk_out   (clk_out),
    .clk_tick  (clk_tick),
    .running   (running),
    .cur_half  (cur_half)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(input int target);
    step(target - cyc);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    step(1);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic count(input int n, output int highs, output int ticks, output int dones);
    highs = 0; ticks = 0; dones = 0;
    repeat (n) begin
      step(1);
      highs += int'(clk_out);
      ticks += int'(clk_tick);
      dones += int'(cfg_done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({clk_out, clk_tick, cfg_done, cfg_ready, running} !== 5'b00011) begin
      bad++; $display("FAIL reset_outs: got %b want 00011",
                      {clk_out, clk_tick, cfg_done, cfg_ready, running}); end
    total++; if (cur_half !== 10'd127) begin
      bad++; $display("FAIL reset_half: got %0d want 127", cur_half); end
    goto(127);
    total++; if (clk_out !== 1'b0) begin
      bad++; $display("FAIL pre_rise: got %b want 0", clk_out); end
    goto(128);
    total++; if ({clk_out, clk_tick} !== 2'b11) begin
      bad++; $display("FAIL rise128: got %b want 11", {clk_out, clk_tick}); end
    goto(129);
    total++; if ({clk_out, clk_tick} !== 2'b10) begin
      bad++; $display("FAIL tick_width: got %b want 10", {clk_out, clk_tick}); end
    goto(255);
    total++; if (clk_out !== 1'b1) begin
      bad++; $display("FAIL high255: got %b want 1", clk_out); end
    goto(256);
    total++; if (clk_out !== 1'b0) begin
      bad++; $display("FAIL fall256: got %b want 0", clk_out); end
    goto(384);
    total++; if (clk_tick !== 1'b1) begin
      bad++; $display("FAIL tick384: got %b want 1", clk_tick); end
    goto(640);
    total++; if (clk_tick !== 1'b1) begin
      bad++; $display("FAIL tick640: got %b want 1", clk_tick); end
  endtask

  task automatic test_reconfig();
    int h, t, d;
    do_reset();
    goto(140);
    cfg_valid = 1'b1; cfg_half = 10'd3; cfg_en = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin
      bad++; $display("FAIL rc_busy: got %b want 0", cfg_ready); end
    goto(255);
    total++; if ({cfg_ready, clk_out, cur_half} !== {2'b01, 10'd127}) begin
      bad++; $display("FAIL rc_pre: got %b/%b/%0d want 0/1/127", cfg_ready, clk_out, cur_half); end
    goto(256);
    total++; if ({cfg_ready, clk_out, cfg_done, cur_half} !== {3'b100, 10'd3}) begin
      bad++; $display("FAIL rc_apply: got %b/%b/%b/%0d want 1/0/0/3",
                      cfg_ready, clk_out, cfg_done, cur_half); end
    goto(257);
    total++; if (cfg_done !== 1'b1) begin
      bad++; $display("FAIL rc_done: got %b want 1", cfg_done); end
    goto(259);
    total++; if (clk_out !== 1'b0) begin
      bad++; $display("FAIL rc_low259: got %b want 0", clk_out); end
    goto(260);
    total++; if ({clk_out, clk_tick} !== 2'b11) begin
      bad++; $display("FAIL rc_rise260: got %b want 11", {clk_out, clk_tick}); end
    goto(263);
    total++; if (clk_out !== 1'b1) begin
      bad++; $display("FAIL rc_high263: got %b want 1", clk_out); end
    goto(264);
    total++; if (clk_out !== 1'b0) begin
      bad++; $display("FAIL rc_fall264: got %b want 0", clk_out); end
    count(40, h, t, d);
    total++; if ({h, t, d} !== {32'd20, 32'd5, 32'd0}) begin
      bad++; $display("FAIL rc_steady: got h=%0d t=%0d d=%0d want 20/5/0", h, t, d); end
  endtask

  task automatic test_disable_enable();
    int h, t, d;
    do_reset();
    cfg_valid = 1'b1; cfg_half = 10'd3; cfg_en = 1'b0;
    step(1);
    cfg_valid = 1'b0;
    goto(255);
    total++; if ({clk_out, running, cur_half} !== {2'b11, 10'd127}) begin
      bad++; $display("FAIL de_pre: got %b/%b/%0d want 1/1/127", clk_out, running, cur_half); end
    goto(256);
    total++; if ({clk_out, running, cur_half} !== {2'b00, 10'd3}) begin
      bad++; $display("FAIL de_off: got %b/%b/%0d want 0/0/3", clk_out, running, cur_half); end
    count(20, h, t, d);
    total++; if ({h, t, d} !== {32'd0, 32'd0, 32'd1}) begin
      bad++; $display("FAIL de_idle: got h=%0d t=%0d d=%0d want 0/0/1", h, t, d); end
    cfg_valid = 1'b1; cfg_half = 10'd0; cfg_en = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    total++; if ({running, clk_out, cfg_done, cur_half} !== {3'b100, 10'd0}) begin
      bad++; $display("FAIL en_accept: got %b/%b/%b/%0d want 1/0/0/0",
                      running, clk_out, cfg_done, cur_half); end
    step(1);
    total++; if ({clk_out, clk_tick, cfg_done} !== 3'b111) begin
      bad++; $display("FAIL en_first: got %b want 111", {clk_out, clk_tick, cfg_done}); end
    count(20, h, t, d);
    total++; if ({h, t, d} !== {32'd10, 32'd10, 32'd0}) begin
      bad++; $display("FAIL en_div2: got h=%0d t=%0d d=%0d want 10/10/0", h, t, d); end
  endtask

  task automatic test_back_to_back();
    int h, t, d;
    do_reset();
    goto(140);
    cfg_valid = 1'b1; cfg_half = 10'd3; cfg_en = 1'b1;
    step(1);
    cfg_half = 10'd7;
    count(114, h, t, d);
    total++; if ({cfg_ready, cur_half, d[3:0]} !== {1'b0, 10'd127, 4'd0}) begin
      bad++; $display("FAIL bb_hold: got rdy=%b half=%0d d=%0d want 0/127/0", cfg_ready, cur_half, d); end
    goto(256);
    total++; if ({cfg_ready, cur_half} !== {1'b1, 10'd3}) begin
      bad++; $display("FAIL bb_apply1: got %b/%0d want 1/3", cfg_ready, cur_half); end
    goto(257);
    cfg_valid = 1'b0;
    total++; if ({cfg_ready, cfg_done, cur_half} !== {2'b01, 10'd3}) begin
      bad++; $display("FAIL bb_accept2: got %b/%b/%0d want 0/1/3", cfg_ready, cfg_done, cur_half); end
    goto(263);
    total++; if ({clk_out, cur_half} !== {1'b1, 10'd3}) begin
      bad++; $display("FAIL bb_pre2: got %b/%0d want 1/3", clk_out, cur_half); end
    goto(264);
    total++; if ({cfg_ready, clk_out, cur_half} !== {2'b10, 10'd7}) begin
      bad++; $display("FAIL bb_apply2: got %b/%b/%0d want 1/0/7", cfg_ready, clk_out, cur_half); end
    goto(265);
    total++; if (cfg_done !== 1'b1) begin
      bad++; $display("FAIL bb_done2: got %b want 1", cfg_done); end
  endtask

  task automatic test_reset_mid();
    int h, t, d;
    do_reset();
    goto(10);
    cfg_valid = 1'b1; cfg_half = 10'd5; cfg_en = 1'b0;
    step(1);
    cfg_valid = 1'b0;
    goto(200);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    cyc = 0;
    total++; if ({cfg_ready, clk_out, cfg_done, running, cur_half} !== {4'b1001, 10'd127}) begin
      bad++; $display("FAIL rm_reset: got %b/%b/%b/%b/%0d want 1/0/0/1/127",
                      cfg_ready, clk_out, cfg_done, running, cur_half); end
    count(300, h, t, d);
    total++; if ({d, running, cur_half} !== {32'd0, 1'b1, 10'd127}) begin
      bad++; $display("FAIL rm_discard: got d=%0d run=%b half=%0d want 0/1/127", d, running, cur_half); end
  endtask

  task automatic test_extremes();
    int h, t, d;
    do_reset();
    cfg_valid = 1'b1; cfg_half = '1; cfg_en = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    goto(256);
    total++; if ({clk_out, cur_half} !== {1'b0, 10'h3FF}) begin
      bad++; $display("FAIL ex_apply: got %b/%0h want 0/3ff", clk_out, cur_half); end
    goto(1279);
    total++; if (clk_out !== 1'b0) begin
      bad++; $display("FAIL ex_low: got %b want 0", clk_out); end
    goto(1280);
    total++; if ({clk_out, clk_tick} !== 2'b11) begin
      bad++; $display("FAIL ex_rise: got %b want 11", {clk_out, clk_tick}); end
    goto(2303);
    total++; if (clk_out !== 1'b1) begin
      bad++; $display("FAIL ex_high: got %b want 1", clk_out); end
    goto(2304);
    total++; if (clk_out !== 1'b0) begin
      bad++; $display("FAIL ex_fall: got %b want 0", clk_out); end
    cfg_valid = 1'b1; cfg_half = 10'd0; cfg_en = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    goto(4351);
    total++; if ({clk_out, cur_half} !== {1'b1, 10'h3FF}) begin
      bad++; $display("FAIL ex_pre0: got %b/%0h want 1/3ff", clk_out, cur_half); end
    goto(4352);
    total++; if ({clk_out, cur_half} !== {1'b0, 10'd0}) begin
      bad++; $display("FAIL ex_apply0: got %b/%0d want 0/0", clk_out, cur_half); end
    count(20, h, t, d);
    total++; if ({h, t, d} !== {32'd10, 32'd10, 32'd1}) begin
      bad++; $display("FAIL ex_div2: got h=%0d t=%0d d=%0d want 10/10/1", h, t, d); end
  endtask

  initial begin
    test_reset();
    test_reconfig();
    test_disable_enable();
    test_back_to_back();
    test_reset_mid();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
